// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//   Two-port front end for the sdram_controller logical interface.
//   Port 0 (SPI emulator) and port 1 (serial command parser) raise a level
//   request; the arbiter acks one of them, issues a single command
//   downstream and routes read data back to the requesting port.
//   Only one command is ever outstanding.
//
//   Command timeline for a request seen in IDLE during cycle k:
//     cycle k+1 : pN_ack high (port fields are sampled at the end of it)
//     cycle k+2 : sd_enable high with the registered command
//
//   Optional feature: define SDRAM_ARB_RR_EN for round-robin arbitration.
//   Without it, port 0 has fixed priority and no pointer register exists.
// ---------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int ADDR_BITS = 25
) (
    input  logic                 clk,
    input  logic                 reset,

    // Port 0: SPI emulator
    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [ADDR_BITS-1:0] p0_addr,
    input  logic [7:0]           p0_wr_data,
    output logic                 p0_ack,
    output logic [7:0]           p0_rd_data,
    output logic                 p0_rd_ready,

    // Port 1: serial command parser
    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [ADDR_BITS-1:0] p1_addr,
    input  logic [7:0]           p1_wr_data,
    output logic                 p1_ack,
    output logic [7:0]           p1_rd_data,
    output logic                 p1_rd_ready,

    // Downstream sdram_controller interface
    output logic [ADDR_BITS-1:0] sd_addr,
    output logic [7:0]           sd_wr_data,
    output logic                 sd_we,
    output logic                 sd_enable,
    input  logic [7:0]           sd_rd_data,
    input  logic                 sd_rd_ready,
    input  logic                 sd_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ACCEPT,
        ST_COMPLETE
    } state_t;

    typedef struct packed {
        logic                 we;
        logic [ADDR_BITS-1:0] addr;
        logic [7:0]           wr_data;
    } cmd_t;

    state_t               r_state;
    state_t               w_next_state;

    // Strobes produced by the next-state logic for the datapath
    logic                 w_any_req;
    logic                 w_sel_port;    // 0 = port 0, 1 = port 1
    logic                 w_do_grant;
    logic                 w_do_issue;
    logic                 w_do_capture;
    cmd_t                 w_port_cmd;

    // Registered outputs and transaction context
    logic                 r_grant;
    logic                 r_p0_ack;
    logic                 r_p1_ack;
    logic [7:0]           r_p0_rd_data;
    logic [7:0]           r_p1_rd_data;
    logic                 r_p0_rd_ready;
    logic                 r_p1_rd_ready;
    logic                 r_sd_enable;
    logic                 r_sd_we;
    logic [ADDR_BITS-1:0] r_sd_addr;
    logic [7:0]           r_sd_wr_data;

    assign w_any_req = p0_req | p1_req;

`ifdef SDRAM_ARB_RR_EN
    // Port granted most recently; reset value makes port 0 win the first tie.
    logic r_last_grant;

    // Round-robin pointer follows every ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_do_grant) begin
            r_last_grant <= w_sel_port;
        end
    end

    // On a tie the port not granted last wins; otherwise the lone requester.
    assign w_sel_port = (p0_req && p1_req) ? ~r_last_grant : p1_req;
`else
    // Fixed priority: port 1 is chosen only when port 0 is not requesting.
    assign w_sel_port = ~p0_req;
`endif

    // Command fields of the granted port, sampled during its ack cycle.
    assign w_port_cmd = r_grant ? cmd_t'{we: p1_we, addr: p1_addr, wr_data: p1_wr_data}
                                : cmd_t'{we: p0_we, addr: p0_addr, wr_data: p0_wr_data};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_state <= w_next_state;
        end
    end

    // Next-state decode and one-cycle datapath strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first; a missing
        // assignment on any path would otherwise infer a latch.
        w_next_state = r_state;
        w_do_grant   = 1'b0;
        w_do_issue   = 1'b0;
        w_do_capture = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A busy controller stalls grants; no ack is given meanwhile.
                if (!sd_busy && w_any_req) begin
                    w_do_grant   = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // Latch the acked port's command and launch sd_enable.
                w_do_issue   = 1'b1;
                w_next_state = ST_ACCEPT;
            end

            ST_ACCEPT: begin
                // A read may finish before busy is ever seen high.
                if (!r_sd_we && sd_rd_ready) begin
                    w_do_capture = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (sd_busy) begin
                    w_next_state = ST_COMPLETE;
                end
            end

            ST_COMPLETE: begin
                if (r_sd_we) begin
                    if (!sd_busy) begin
                        w_next_state = ST_IDLE;
                    end
                end else if (sd_rd_ready) begin
                    w_do_capture = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Grant bookkeeping and ack pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant  <= 1'b0;
            r_p0_ack <= 1'b0;
            r_p1_ack <= 1'b0;
        end else begin
            r_p0_ack <= w_do_grant & ~w_sel_port;
            r_p1_ack <= w_do_grant &  w_sel_port;
            if (w_do_grant) begin
                r_grant <= w_sel_port;
            end
        end
    end

    // Downstream command registers; held from issue until the next issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sd_enable  <= 1'b0;
            r_sd_we      <= 1'b0;
            r_sd_addr    <= '0;
            r_sd_wr_data <= '0;
        end else begin
            r_sd_enable <= w_do_issue;
            if (w_do_issue) begin
                r_sd_we      <= w_port_cmd.we;
                r_sd_addr    <= w_port_cmd.addr;
                r_sd_wr_data <= w_port_cmd.wr_data;
            end
        end
    end

    // Read return: only the granted port's data and valid pulse move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p0_rd_data  <= '0;
            r_p1_rd_data  <= '0;
            r_p0_rd_ready <= 1'b0;
            r_p1_rd_ready <= 1'b0;
        end else begin
            r_p0_rd_ready <= w_do_capture & ~r_grant;
            r_p1_rd_ready <= w_do_capture &  r_grant;
            if (w_do_capture && !r_grant) begin
                r_p0_rd_data <= sd_rd_data;
            end
            if (w_do_capture && r_grant) begin
                r_p1_rd_data <= sd_rd_data;
            end
        end
    end

    assign p0_ack      = r_p0_ack;
    assign p1_ack      = r_p1_ack;
    assign p0_rd_data  = r_p0_rd_data;
    assign p1_rd_data  = r_p1_rd_data;
    assign p0_rd_ready = r_p0_rd_ready;
    assign p1_rd_ready = r_p1_rd_ready;
    assign sd_enable   = r_sd_enable;
    assign sd_we       = r_sd_we;
    assign sd_addr     = r_sd_addr;
    assign sd_wr_data  = r_sd_wr_data;

endmodule

// File: tb/tb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbiter
//   Directed bench for sdram_arbiter. The bench plays both requesters and a
//   simple sdram_controller: busy rises the cycle after sd_enable, writes
//   hold busy for three cycles, reads return data after a given latency.
//   Expected tie order follows SDRAM_ARB_RR_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_sdram_arbiter;

    localparam int ADDR_BITS = 25;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;

    logic                 p0_req = 1'b0, p0_we = 1'b0;
    logic [ADDR_BITS-1:0] p0_addr = '0;
    logic [7:0]           p0_wr_data = '0;
    logic                 p0_ack, p0_rd_ready;
    logic [7:0]           p0_rd_data;

    logic                 p1_req = 1'b0, p1_we = 1'b0;
    logic [ADDR_BITS-1:0] p1_addr = '0;
    logic [7:0]           p1_wr_data = '0;
    logic                 p1_ack, p1_rd_ready;
    logic [7:0]           p1_rd_data;

    logic [ADDR_BITS-1:0] sd_addr;
    logic [7:0]           sd_wr_data;
    logic                 sd_we, sd_enable;
    logic [7:0]           sd_rd_data = '0;
    logic                 sd_rd_ready = 1'b0;
    logic                 sd_busy = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // Pulse counters and ack order, sampled mid-cycle
    int n_ack0 = 0, n_ack1 = 0, n_en = 0, n_rr0 = 0, n_rr1 = 0;
    int ack_log[$];

    sdram_arbiter #(.ADDR_BITS(ADDR_BITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .p0_req      (p0_req),
        .p0_we       (p0_we),
        .p0_addr     (p0_addr),
        .p0_wr_data  (p0_wr_data),
        .p0_ack      (p0_ack),
        .p0_rd_data  (p0_rd_data),
        .p0_rd_ready (p0_rd_ready),
        .p1_req      (p1_req),
        .p1_we       (p1_we),
        .p1_addr     (p1_addr),
        .p1_wr_data  (p1_wr_data),
        .p1_ack      (p1_ack),
        .p1_rd_data  (p1_rd_data),
        .p1_rd_ready (p1_rd_ready),
        .sd_addr     (sd_addr),
        .sd_wr_data  (sd_wr_data),
        .sd_we       (sd_we),
        .sd_enable   (sd_enable),
        .sd_rd_data  (sd_rd_data),
        .sd_rd_ready (sd_rd_ready),
        .sd_busy     (sd_busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor on the falling edge.
    always @(negedge clk) begin
        if (p0_ack) begin n_ack0++; ack_log.push_back(0); end
        if (p1_ack) begin n_ack1++; ack_log.push_back(1); end
        if (sd_enable)   n_en++;
        if (p0_rd_ready) n_rr0++;
        if (p1_rd_ready) n_rr1++;
    end

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {9'd0, p0_ack, p1_ack, p0_rd_ready, p1_rd_ready, sd_enable, sd_we,
                sd_addr, sd_wr_data, p0_rd_data, p1_rd_data};
    endfunction

    // Raise one port's request, drop it on its ack, return at sd_enable.
    task automatic request(input bit port, input bit we, input logic [ADDR_BITS-1:0] addr,
                           input logic [7:0] wdata, output int ack_idx, output int en_idx,
                           output logic [ADDR_BITS-1:0] e_addr, output logic e_we,
                           output logic [7:0] e_wd);
        @(posedge clk); #1;
        if (port) begin p1_we = we; p1_addr = addr; p1_wr_data = wdata; p1_req = 1'b1; end
        else      begin p0_we = we; p0_addr = addr; p0_wr_data = wdata; p0_req = 1'b1; end
        ack_idx = -1; en_idx = -1; e_addr = '0; e_we = 1'b0; e_wd = '0;
        for (int i = 0; i < 16 && en_idx < 0; i++) begin
            @(negedge clk);
            if (ack_idx < 0 && (port ? p1_ack : p0_ack)) begin
                ack_idx = i;
                if (port) p1_req = 1'b0; else p0_req = 1'b0;
            end
            if (sd_enable) begin
                en_idx = i; e_addr = sd_addr; e_we = sd_we; e_wd = sd_wr_data;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
    endtask

    // Controller model, called from the negedge of the sd_enable cycle.
    task automatic serve(input bit we, input int lat, input logic [7:0] rdata);
        @(posedge clk); #1;
        sd_busy = 1'b1;
        if (we) begin
            repeat (3) @(posedge clk);
            #1 sd_busy = 1'b0;
        end else begin
            repeat (lat - 1) @(posedge clk);
            #1 sd_rd_data = rdata; sd_rd_ready = 1'b1;
            @(posedge clk);
            #1 sd_rd_ready = 1'b0; sd_busy = 1'b0;
        end
    endtask

    initial begin
        int ack_idx, en_idx, base, s_ack0, s_ack1, s_en, s_rr0, s_rr1;
        logic [ADDR_BITS-1:0] e_addr;
        logic e_we, seen;
        logic [7:0] e_wd;
        logic [3:0] tie_seq;
`ifdef SDRAM_ARB_RR_EN
        tie_seq = 4'b1010;
`else
        tie_seq = 4'b0000;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", out_vec(), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Port 0 write of 0x5A to the top address
        s_ack0 = n_ack0; s_ack1 = n_ack1; s_en = n_en; s_rr0 = n_rr0; s_rr1 = n_rr1;
        request(1'b0, 1'b1, 25'h1FFFFFF, 8'h5A, ack_idx, en_idx, e_addr, e_we, e_wd);
        check("wr_ack_latency", ack_idx, 1);
        check("wr_en_latency",  en_idx, 2);
        check("wr_sd_addr",     e_addr, 25'h1FFFFFF);
        check("wr_sd_we",       e_we, 1'b1);
        check("wr_sd_wr_data",  e_wd, 8'h5A);
        if (en_idx >= 0) serve(1'b1, 0, 8'h00);

        // Port 1 read straight after: a 1-cycle ack proves the FSM is IDLE
        request(1'b1, 1'b0, 25'h0000123, 8'h00, ack_idx, en_idx, e_addr, e_we, e_wd);
        check("rd_ack_latency", ack_idx, 1);
        check("rd_en_latency",  en_idx, 2);
        check("rd_sd_addr",     e_addr, 25'h0000123);
        check("rd_sd_we",       e_we, 1'b0);
        if (en_idx >= 0) serve(1'b0, 6, 8'hA5);
        repeat (3) @(posedge clk); #1;
        check("p0_ack_count",   n_ack0 - s_ack0, 1);
        check("p1_ack_count",   n_ack1 - s_ack1, 1);
        check("sd_enable_count", n_en - s_en, 2);
        check("p0_rd_ready_count", n_rr0 - s_rr0, 0);
        check("p1_rd_ready_count", n_rr1 - s_rr1, 1);
        check("p1_rd_data",     p1_rd_data, 8'hA5);
        check("p0_rd_data_untouched", p0_rd_data, 8'h00);

        // Both ports requesting for four transactions
        base = ack_log.size();
        @(posedge clk); #1;
        p0_we = 1'b1; p0_addr = 25'h0000AA0; p0_wr_data = 8'h11;
        p1_we = 1'b1; p1_addr = 25'h0000BB1; p1_wr_data = 8'h22;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            seen = 1'b0; e_addr = '0;
            for (int i = 0; i < 16 && !seen; i++) begin
                @(negedge clk);
                if (sd_enable) begin seen = 1'b1; e_addr = sd_addr; end
            end
            check($sformatf("tie_sd_addr_%0d", t), e_addr,
                  tie_seq[t] ? 25'h0000BB1 : 25'h0000AA0);
            if (seen) serve(1'b1, 0, 8'h00);
        end
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("tie_ack_total", ack_log.size() - base, 4);
        for (int t = 0; t < 4; t++) begin
            check($sformatf("tie_ack_port_%0d", t),
                  (base + t < ack_log.size()) ? ack_log[base + t] : -1, tie_seq[t]);
        end

        // Controller busy for 20 cycles while port 1 requests
        s_ack1 = n_ack1; s_en = n_en;
        @(posedge clk); #1;
        sd_busy = 1'b1;
        p1_we = 1'b1; p1_addr = 25'h0ABCDEF; p1_wr_data = 8'h77; p1_req = 1'b1;
        repeat (20) @(negedge clk);
        check("stall_no_ack",    n_ack1 - s_ack1, 0);
        check("stall_no_enable", n_en - s_en, 0);
        @(posedge clk); #1 sd_busy = 1'b0;
        ack_idx = -1; en_idx = -1; e_addr = '0;
        for (int i = 0; i < 16 && en_idx < 0; i++) begin
            @(negedge clk);
            if (ack_idx < 0 && p1_ack) begin ack_idx = i; p1_req = 1'b0; end
            if (sd_enable) begin en_idx = i; e_addr = sd_addr; end
        end
        p1_req = 1'b0;
        check("stall_release_ack", ack_idx, 1);
        check("stall_sd_addr", e_addr, 25'h0ABCDEF);
        if (en_idx >= 0) serve(1'b1, 0, 8'h00);
        repeat (2) @(posedge clk);

        // Reset in COMPLETE during a port 0 read, then a stray sd_rd_ready
        s_rr0 = n_rr0; s_rr1 = n_rr1;
        request(1'b0, 1'b0, 25'h0000456, 8'h00, ack_idx, en_idx, e_addr, e_we, e_wd);
        @(posedge clk); #1 sd_busy = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        #1 check("midtxn_reset_outputs", out_vec(), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1 sd_rd_data = 8'hEE; sd_rd_ready = 1'b1;
        @(posedge clk); #1 sd_rd_ready = 1'b0; sd_busy = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("abandoned_no_rd_ready", n_rr0 - s_rr0, 0);
        check("abandoned_rd_data",     p0_rd_data, 8'h00);

        // Next request after reset is served normally
        request(1'b0, 1'b0, 25'h0000789, 8'h00, ack_idx, en_idx, e_addr, e_we, e_wd);
        check("post_reset_ack_latency", ack_idx, 1);
        check("post_reset_sd_addr",     e_addr, 25'h0000789);
        if (en_idx >= 0) serve(1'b0, 4, 8'h3C);
        repeat (3) @(posedge clk); #1;
        check("post_reset_p0_rd_data",  p0_rd_data, 8'h3C);
        check("post_reset_p0_rd_ready", n_rr0 - s_rr0, 1);
        check("post_reset_p1_untouched", {p1_rd_data, 24'(n_rr1 - s_rr1)}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 25, SHALL set the SDRAM byte-address width.
REQ-002 Port clk, input, 1: SHALL be the single clock; all logic is rising-edge.
REQ-003 Port reset, input, 1: SHALL be an asynchronous, active-high reset.
REQ-004 Ports p0_req / p1_req, input, 1: SHALL be the per-port level request, held until the matching ack; port 0 is the SPI emulator, port 1 is the serial command parser.
REQ-005 Ports pN_we, input, 1; pN_addr, input, ADDR_BITS; pN_wr_data, input, 8: SHALL be sampled only in the cycle pN_ack is high.
REQ-006 Ports pN_ack, output, 1: SHALL give a one-cycle pulse when the port's command is issued downstream.
REQ-007 Ports pN_rd_data, output, 8; pN_rd_ready, output, 1: SHALL return read data with a one-cycle valid pulse.
REQ-008 Downstream outputs sd_addr (ADDR_BITS), sd_wr_data (8), sd_we (1), sd_enable (1): SHALL drive the sdram_controller logical interface.
REQ-009 Downstream inputs sd_rd_data (8), sd_rd_ready (1), sd_busy (1): SHALL come from sdram_controller.

Function
REQ-010 FSM states SHALL be IDLE, ISSUE, ACCEPT, COMPLETE.
REQ-011 IDLE, when sd_busy=0 and any req=1: SHALL select the grant per REQ-017, register addr/we/wr_data from the granted port, pulse that port's ack, and go to ISSUE.
REQ-012 ISSUE: SHALL assert sd_enable for exactly one cycle with the registered command, then go to ACCEPT.
REQ-013 ACCEPT: SHALL wait for sd_busy=1, then go to COMPLETE; if sd_rd_ready=1 arrives first on a read, it SHALL be handled as in REQ-014.
REQ-014 COMPLETE, read: on sd_rd_ready=1, SHALL capture sd_rd_data into the granted port's rd_data, pulse its rd_ready the next cycle, and return to IDLE.
REQ-015 COMPLETE, write: on sd_busy=0, SHALL return to IDLE; no rd_ready pulse SHALL occur.
REQ-016 Request-to-sd_enable latency SHALL be 2 cycles when IDLE and sd_busy=0; at most one command SHALL be outstanding.
REQ-017 Default arbitration SHALL be fixed priority: port 0 wins whenever both requests are high in IDLE.
REQ-018 rd_ready and rd_data of the non-granted port SHALL NOT change.
REQ-019 A req dropped before its ack SHALL be ignored; a req still high after its ack SHALL be treated as a new request at the next IDLE.
REQ-020 sd_busy=1 in IDLE SHALL stall grants with no ack issued.
REQ-021 sd_we, sd_addr and sd_wr_data SHALL hold stable from ISSUE until return to IDLE.

Reset
REQ-022 Asserting reset SHALL immediately force IDLE, and drive sd_enable, sd_we, both acks and both rd_ready to 0, and sd_addr, sd_wr_data and both rd_data to 0.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction; a later sd_rd_ready SHALL produce no rd_ready pulse.
REQ-024 After reset deasserts, the round-robin pointer (when compiled in) SHALL favour port 0.

Configuration
REQ-025 Macro SDRAM_ARB_RR_EN: when defined, arbitration SHALL be round-robin; on a tie, the port not granted last SHALL win; the pointer SHALL update on each ack.
REQ-026 Without SDRAM_ARB_RR_EN, arbitration SHALL be fixed priority per REQ-017, and no pointer register SHALL exist.

Verification
REQ-027 Port 1 read of addr 0x000123, model returns 0xA5 after 6 cycles -> p1_ack once; sd_enable is one cycle with sd_addr=0x000123 and sd_we=0; p1_rd_data=0xA5 with p1_rd_ready pulsed once.
REQ-028 Port 0 write of 0x5A to 0x1FFFFFF -> one sd_enable with sd_we=1; FSM back in IDLE once sd_busy falls; no rd_ready on either port.
REQ-029 p0_req and p1_req high together for 4 transactions -> fixed: acks 0,0,0,0; with SDRAM_ARB_RR_EN: acks 0,1,0,1.
REQ-030 sd_busy held at 1 for 20 cycles while p1_req=1 -> no ack and no sd_enable until sd_busy=0, then ack within 1 cycle.
REQ-031 Reset pulsed in COMPLETE during a port 0 read, then sd_rd_ready asserted -> all outputs 0; p0_rd_ready never pulses; next request is served normally.
